// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Packs register/function fields and a decode-style 32-bit immediate back into
// an RV32I instruction word. This is the inverse of the immediate-extension
// path. It feeds the boot/debug instruction-injection path into fetch.
//
// Structure:
// - The encoder is combinational. Its result is registered straight into a
//   small output FIFO, so the first word appears one cycle after acceptance.
//   There is no combinational path from the input side to the output side.
// - The FIFO head is held in output registers. out_instr and out_err therefore
//   stay stable while the consumer stalls, and keep their last value when the
//   FIFO is empty.
//
// Parameters:
//   FIFO_DEPTH  output buffer entries (power of two, >= 2)
//   CNT_W       width of the encoded-instruction counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request valid
//   in_ready   encoder can accept (FIFO not full, forced low in reset)
//   in_type    000 I, 001 S, 010 B, 011 J, 100 U, 101 R, 110/111 illegal
//   in_opcode  opcode field
//   in_rd      destination register
//   in_rs1     source register 1
//   in_rs2     source register 2
//   in_funct3  funct3 field
//   in_funct7  funct7 field (R-type only)
//   in_imm     byte-offset / value immediate as produced by decode extension
//   out_valid  encoded word available
//   out_ready  consumer accepts
//   out_instr  encoded instruction word
//   out_err    word flagged (illegal type, or unrepresentable immediate)
//   enc_count  number of words transferred on the output side (wraps)
//
// Build option:
//   INSTR_ENC_RANGE_CHECK_EN
//     When defined, out_err is also raised if in_imm cannot be represented by
//     the selected type. The word is still encoded by truncation.
//     When undefined, no range-check logic is built.
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_type,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  // FIFO_DEPTH is a power of two and at least 2, so PTR_W is at least 1 and
  // the pointers wrap naturally modulo the depth.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [31:0]      NOP_WORD = 32'h0000_0013;   // addi x0,x0,0

  typedef enum logic [2:0] {
    TYPE_I = 3'b000,
    TYPE_S = 3'b001,
    TYPE_B = 3'b010,
    TYPE_J = 3'b011,
    TYPE_U = 3'b100,
    TYPE_R = 3'b101
  } imm_type_e;

  imm_type_e type_sel;
  assign type_sel = imm_type_e'(in_type);

  // ---------------------------------------------------------------------------
  // Field packing
  // ---------------------------------------------------------------------------
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        enc_err;

  always_comb begin
    enc_word    = NOP_WORD;
    enc_illegal = 1'b0;
    case (type_sel)
      TYPE_I: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      TYPE_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:0], in_opcode};
      TYPE_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
      TYPE_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                          in_rd, in_opcode};
      TYPE_U: enc_word = {in_imm[31:12], in_rd, in_opcode};
      TYPE_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      default: begin
        // Codes 110/111: inject a harmless NOP and flag it.
        enc_word    = NOP_WORD;
        enc_illegal = 1'b1;
      end
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // An immediate is representable when every bit above the encoded sign bit
  // equals that sign bit. Branch and jump offsets must also be even, because
  // bit 0 is not encoded for them. U-type carries only the upper 20 bits.
  logic imm_unrep;

  always_comb begin
    imm_unrep = 1'b0;
    case (type_sel)
      TYPE_I, TYPE_S: imm_unrep = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      TYPE_B:         imm_unrep = !((&in_imm[31:12]) || !(|in_imm[31:12]))
                                  || in_imm[0];
      TYPE_J:         imm_unrep = !((&in_imm[31:20]) || !(|in_imm[31:20]))
                                  || in_imm[0];
      TYPE_U:         imm_unrep = |in_imm[11:0];
      default:        imm_unrep = 1'b0;
    endcase
  end

  assign enc_err = enc_illegal || imm_unrep;
`else
  assign enc_err = enc_illegal;
`endif

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]      mem_instr [FIFO_DEPTH];
  logic             mem_err   [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [OCC_W-1:0] count_reg;
  logic [OCC_W-1:0] count_next;
  logic [31:0]      out_instr_reg;
  logic             out_err_reg;
  logic [CNT_W-1:0] enc_count_reg;

  logic             push;
  logic             pop;
  logic             head_from_input;
  logic [31:0]      head_instr;
  logic             head_err;

  // Ready depends only on occupancy (and reset), never on in_valid. A full
  // FIFO therefore refuses a push even while it is popping in the same cycle.
  assign in_ready  = rst_n && (count_reg != OCC_FULL);
  assign out_valid = (count_reg != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_next = push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    count_next  = count_reg + OCC_W'(push) - OCC_W'(pop);

    // The incoming word becomes the new head when nothing else remains ahead
    // of it. In that case it lands at the slot that rd_ptr_next selects.
    // Storage still holds the old contents of that slot this cycle, so the
    // new word is bypassed straight into the output registers.
    head_from_input = push && (wr_ptr_reg == rd_ptr_next);
    head_instr      = head_from_input ? enc_word : mem_instr[rd_ptr_next];
    head_err        = head_from_input ? enc_err  : mem_err[rd_ptr_next];
  end

  // Storage array. It has no reset: entries are only meaningful below the
  // occupancy count, and a reset clears the count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_reg] <= enc_word;
      mem_err[wr_ptr_reg]   <= enc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_instr_reg <= '0;
      out_err_reg   <= 1'b0;
      enc_count_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      // Load the next head only when one exists. Otherwise the output holds
      // the last word shown.
      if (count_next != '0) begin
        out_instr_reg <= head_instr;
        out_err_reg   <= head_err;
      end
      if (pop) begin
        enc_count_reg <= enc_count_reg + CNT_W'(1);
      end
    end
  end

  assign out_instr = out_instr_reg;
  assign out_err   = out_err_reg;
  assign enc_count = enc_count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed testbench for instr_encoder. Each scenario task drives its own
// stimulus and compares the outputs against hand-computed values.
// Inputs are driven, and outputs sampled, 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int CNT_W = 16;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_type;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;

  int               vectors;
  int               miscompares;
  logic [CNT_W-1:0] exp_cnt;

  typedef struct packed {
    logic [2:0]  t;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  instr_encoder #(
    .FIFO_DEPTH(2),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_type  (in_type),
    .in_opcode(in_opcode),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_funct3(in_funct3),
    .in_funct7(in_funct7),
    .in_imm   (in_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_err  (out_err),
    .enc_count(enc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid  = 1'b1;
    in_type   = v.t;
    in_opcode = v.op;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_imm    = v.imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive('{3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'd0, 1'b0});
    tick();
    tick();
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready_low got %b want 0", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    vectors++;
    if (out_instr !== 32'h0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_word got %h/%b want 00000000/0", out_instr, out_err);
    end
    vectors++;
    if (enc_count !== '0) begin
      miscompares++;
      $display("FAIL reset_enc_count got %0d want 0", enc_count);
    end
    idle();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_in_ready got %b want 1", in_ready);
    end
    exp_cnt = '0;
    $display("txn reset done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_i_type();
    out_ready = 1'b1;
    drive('{3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'd0, 1'b0});
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL i_type_in_ready got %b want 1", in_ready);
    end
    tick();
    idle();
    vectors++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0050_0093 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL i_type_word got v=%b %h e=%b want v=1 00500093 e=0",
               out_valid, out_instr, out_err);
    end
    tick();
    exp_cnt = exp_cnt + 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || enc_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL i_type_count got v=%b cnt=%0d want v=0 cnt=%0d",
               out_valid, enc_count, exp_cnt);
    end
    $display("txn i_type instr=%h err=%b", out_instr, out_err);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive('{3'b001, 7'h23, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'd0, 1'b0});
    tick();
    drive('{3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFC, 32'd0, 1'b0});
    vectors++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0020_A423 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_s_word got v=%b %h e=%b want v=1 0020a423 e=0",
               out_valid, out_instr, out_err);
    end
    $display("txn b2b S instr=%h", out_instr);
    tick();
    idle();
    exp_cnt = exp_cnt + 1'b1;
    vectors++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFE00_0EE3 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_b_word got v=%b %h e=%b want v=1 fe000ee3 e=0",
               out_valid, out_instr, out_err);
    end
    $display("txn b2b B instr=%h", out_instr);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || enc_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL b2b_drain got v=%b cnt=%0d want v=0 cnt=%0d",
               out_valid, enc_count, exp_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Each entry is one isolated request. rs2 / imm values on types that do
  // not use them are deliberately nonzero, to show that they are ignored.
  task automatic test_encodings();
    vec_t tab [8];
    tab[0] = '{3'b011, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0};
    tab[1] = '{3'b100, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    tab[2] = '{3'b101, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0};
    tab[3] = '{3'b110, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, 32'h0000_0013, 1'b1};
    tab[4] = '{3'b111, 7'h6F, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1};
    tab[5] = '{3'b000, 7'h13, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFF_F800, 32'h8000_0093, 1'b0};
    // Range-check vectors: same encoding either way, flag depends on build.
    tab[6] = '{3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0003, 32'h0000_0163, RC};
    tab[7] = '{3'b100, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, RC};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(tab[i]);
      tick();
      idle();
      vectors++;
      if (out_valid !== 1'b1 || out_instr !== tab[i].exp_instr || out_err !== tab[i].exp_err) begin
        miscompares++;
        $display("FAIL encode_%0d got v=%b %h e=%b want v=1 %h e=%b",
                 i, out_valid, out_instr, out_err, tab[i].exp_instr, tab[i].exp_err);
      end
      $display("txn encode_%0d type=%b instr=%h err=%b", i, tab[i].t, out_instr, out_err);
      tick();
      exp_cnt = exp_cnt + 1'b1;
    end
    vectors++;
    if (enc_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL encode_count got %0d want %0d", enc_count, exp_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_range_extra();
    vec_t tab [2];
    // J offset with bit 20 set but bit 21+ clear: out of range, encodes bit 31.
    tab[0] = '{3'b011, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h8000_00EF, RC};
    // I immediate +2048 does not fit in 12 signed bits.
    tab[1] = '{3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_0093, RC};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(tab[i]);
      tick();
      idle();
      vectors++;
      if (out_valid !== 1'b1 || out_instr !== tab[i].exp_instr || out_err !== tab[i].exp_err) begin
        miscompares++;
        $display("FAIL range_%0d got v=%b %h e=%b want v=1 %h e=%b",
                 i, out_valid, out_instr, out_err, tab[i].exp_instr, tab[i].exp_err);
      end
      $display("txn range_%0d instr=%h err=%b", i, out_instr, out_err);
      tick();
      exp_cnt = exp_cnt + 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    out_ready = 1'b0;
    drive('{3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'd0, 1'b0});
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_accept_a got %b want 1", in_ready);
    end
    tick();
    drive('{3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'd0, 1'b0});
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_accept_b got %b want 1", in_ready);
    end
    tick();
    drive('{3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'd0, 1'b0});
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full_ready got %b want 0", in_ready);
    end
    tick();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h0010_0093) begin
      miscompares++;
      $display("FAIL bp_stall got rdy=%b v=%b %h want rdy=0 v=1 00100093",
               in_ready, out_valid, out_instr);
    end
    $display("txn bp stalled head=%h", out_instr);
    // Full FIFO with consumer ready: the pop happens, but no push this cycle.
    out_ready = 1'b1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full_pop_ready got %b want 0", in_ready);
    end
    tick();
    exp_cnt = exp_cnt + 1'b1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_instr !== 32'h0020_0093) begin
      miscompares++;
      $display("FAIL bp_second got rdy=%b v=%b %h want rdy=1 v=1 00200093",
               in_ready, out_valid, out_instr);
    end
    $display("txn bp pop head=%h", out_instr);
    tick();
    idle();
    exp_cnt = exp_cnt + 1'b1;
    vectors++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0030_0093) begin
      miscompares++;
      $display("FAIL bp_third got v=%b %h want v=1 00300093", out_valid, out_instr);
    end
    $display("txn bp pop head=%h", out_instr);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || enc_count !== exp_cnt || out_instr !== 32'h0030_0093) begin
      miscompares++;
      $display("FAIL bp_drain got v=%b cnt=%0d %h want v=0 cnt=%0d 00300093",
               out_valid, enc_count, out_instr, exp_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive('{3'b100, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'd0, 1'b0});
    tick();
    drive('{3'b110, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b0});
    tick();
    idle();
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_instr !== 32'h1234_52B7) begin
      miscompares++;
      $display("FAIL mid_full got v=%b rdy=%b %h want v=1 rdy=0 123452b7",
               out_valid, in_ready, out_instr);
    end
    rst_n = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || enc_count !== '0 || out_instr !== 32'h0 ||
        out_err !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got v=%b cnt=%0d %h e=%b rdy=%b want v=0 cnt=0 00000000 e=0 rdy=0",
               out_valid, enc_count, out_instr, out_err, in_ready);
    end
    rst_n = 1'b1;
    exp_cnt = '0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_release_ready got %b want 1", in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0 || enc_count !== exp_cnt) begin
        miscompares++;
        $display("FAIL mid_no_stale_%0d got v=%b cnt=%0d want v=0 cnt=0",
                 i, out_valid, enc_count);
      end
    end
    $display("txn midstream reset cleared");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_cnt     = '0;
    in_valid    = 1'b0;
    in_type     = 3'b000;
    in_opcode   = 7'h0;
    in_rd       = 5'd0;
    in_rs1      = 5'd0;
    in_rs2      = 5'd0;
    in_funct3   = 3'd0;
    in_funct7   = 7'd0;
    in_imm      = 32'd0;
    out_ready   = 1'b0;
    rst_n       = 1'b0;

    test_reset();
    test_i_type();
    test_back_to_back();
    test_encodings();
    test_range_extra();
    test_backpressure();
    test_reset_midstream();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
